// File: rtl/hatch_server.sv
// Instruction-side responder for the CPU hatch fetch port, with a byte-serial
// program loader that refills the store while holding the CPU in reset.
module hatch_server #(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [47:0] NOP_INSN = 48'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       hatch_address,
  output logic [47:0]       hatch_instruction,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  output logic              cpu_rst_b,
  output logic [ADDR_W:0]   load_count,
  output logic              load_err
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam logic [16:0] DEPTH17 = 17'(DEPTH);

  typedef enum logic [2:0] {RUN, HDR_HI, HDR_LO, DATA, RELEASE} state_t;

  state_t      state, state_nxt;
  logic [47:0] mem [DEPTH];
  logic [7:0]  n_hi;
  logic [15:0] n_total;
  logic [15:0] idx;
  logic [2:0]  byte_cnt;
  logic [47:0] asm_q;

  logic        accept;
  logic        word_done;
  logic [47:0] word;
  logic [15:0] idx_inc;
  logic [16:0] idx_inc17;
  logic [16:0] lc_sat;
  logic [15:0] hdr_n;

  assign accept    = ld_valid & ld_ready;
  assign word_done = (state == DATA) && accept && (byte_cnt == 3'd5);
  assign word      = {asm_q[39:0], ld_byte};
  assign idx_inc   = idx + 16'd1;
  assign idx_inc17 = {1'b0, idx} + 17'd1;
  assign lc_sat    = (idx_inc17 > DEPTH17) ? DEPTH17 : idx_inc17;
  assign hdr_n     = {n_hi, ld_byte};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (ld_start) state_nxt = HDR_HI;
      HDR_HI:  if (accept) state_nxt = HDR_LO;
      HDR_LO:  if (accept) state_nxt = (hdr_n == 16'd0) ? RELEASE : DATA;
      DATA:    if (word_done && (idx_inc == n_total)) state_nxt = RELEASE;
      RELEASE: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    ld_ready = 1'b0;
    unique case (state)
      HDR_HI, HDR_LO, DATA: ld_ready = 1'b1;
      default:              ld_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rst_b  <= 1'b0;
      load_count <= '0;
      load_err   <= 1'b0;
      n_hi       <= '0;
      n_total    <= '0;
      idx        <= '0;
      byte_cnt   <= '0;
      asm_q      <= '0;
    end else begin
      unique case (state)
        RUN: begin
          cpu_rst_b <= ~ld_start;
          if (ld_start) begin
            load_err   <= 1'b0;
            load_count <= '0;
            idx        <= '0;
            byte_cnt   <= '0;
            asm_q      <= '0;
          end
        end
        HDR_HI: if (accept) n_hi <= ld_byte;
        HDR_LO: if (accept) begin
          n_total <= hdr_n;
          if ({1'b0, hdr_n} > DEPTH17) load_err <= 1'b1;
        end
        DATA: if (accept) begin
          asm_q <= word;
          if (byte_cnt == 3'd5) begin
            byte_cnt   <= '0;
            idx        <= idx_inc;
            load_count <= lc_sat[ADDR_W:0];
          end else begin
            byte_cnt <= byte_cnt + 3'd1;
          end
        end
        RELEASE: cpu_rst_b <= 1'b1;
        default: cpu_rst_b <= 1'b0;
      endcase
    end
  end

  // Words past the store depth are still consumed from the stream but dropped.
  always_ff @(posedge clk) begin
    if (word_done && ({1'b0, idx} < DEPTH17)) mem[idx[ADDR_W-1:0]] <= word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hatch_instruction <= NOP_INSN;
    else if (hatch_address[31:ADDR_W] == '0)
      hatch_instruction <= mem[hatch_address[ADDR_W-1:0]];
    else
      hatch_instruction <= NOP_INSN;
  end

endmodule

// File: doc/hatch_server.md
Name: hatch_server

Overview:
Instruction-side responder for the CPU's hatch fetch port. It drives `hatch_instruction` from an on-chip 48-bit program store, indexed by `hatch_address`. It also owns a byte-serial program loader that refills the store while it holds the CPU in reset through `cpu_rst_b`. It sits beside the CPU at top level, between the board load interface and the CPU's `hatch_address`/`hatch_instruction` pins.

Parameters:
- ADDR_W, 10, log2 of store depth in 48-bit instructions (depth = 2^ADDR_W).
- NOP_INSN, 48'h0, word returned for out-of-range fetches.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- hatch_address  input  32  fetch index, in instruction words (not bytes).
- hatch_instruction  output  48  fetched word, registered, 1-cycle latency.
- ld_start  input  1  single-cycle pulse that begins a program load.
- ld_valid  input  1  `ld_byte` is valid this cycle.
- ld_byte  input  8  load stream byte.
- ld_ready  output  1  loader accepts a byte when `ld_valid` and `ld_ready` are both high.
- cpu_rst_b  output  1  active-low reset to the CPU.
- load_count  output  ADDR_W+1  number of instructions written by the most recent load.
- load_err  output  1  sticky flag: the last load declared more instructions than the store depth.

Behaviour:
- Reset (async, rst=1):
  - state=RUN, `hatch_instruction`=NOP_INSN, `ld_ready`=0, `cpu_rst_b`=0, `load_count`=0, `load_err`=0.
  - Byte counter and assembly register cleared.
  - Store contents are not reset.
- `cpu_rst_b` is registered. It goes to 1 on the first clk edge after rst deasserts while state=RUN.
- Read path, every cycle in every state:
  - If `hatch_address[31:ADDR_W]` == 0, `hatch_instruction` <= mem[`hatch_address[ADDR_W-1:0]`] at the next edge.
  - Otherwise `hatch_instruction` <= NOP_INSN.
  - Latency is exactly 1 cycle.
- Stream format: 2-byte big-endian count N, then N instructions of 6 bytes each, most-significant byte first.
- States:
  - RUN: `ld_ready`=0; `ld_valid` is ignored. `ld_start` -> HDR_HI, `cpu_rst_b`<=0, `load_err`<=0, `load_count`<=0.
  - HDR_HI: `ld_ready`=1. On accept, N[15:8] is captured -> HDR_LO.
  - HDR_LO: `ld_ready`=1. On accept, N[7:0] is captured. If N==0 -> RELEASE, else -> DATA.
    - If N > 2^ADDR_W, `load_err`<=1.
  - DATA: `ld_ready`=1. Each accepted byte shifts into a 48-bit assembly register and increments the byte counter (0..5).
    - On the 6th byte, the full word (with the new byte as LSB) is written to mem[index] and the byte counter wraps to 0.
    - The write is suppressed when index >= 2^ADDR_W.
    - `load_count` <= min(index+1, 2^ADDR_W).
    - index increments. When index reaches N -> RELEASE.
  - RELEASE: `ld_ready`=0, one cycle only -> RUN. `cpu_rst_b`<=1 on this edge, so the CPU restarts at index 0 with the new image.
- `ld_start` outside RUN is ignored; a load cannot be restarted mid-stream except by rst.
- Gaps in the stream are allowed: `ld_valid` low simply stalls the load; there is no timeout.
- Asserting rst mid-load:
  - State returns to RUN and the partial word is discarded.
  - Words already written remain in the store.
  - `cpu_rst_b` is 0 during rst and 1 after.
- A store write and a fetch of the same index in the same cycle returns the old data (read-first). No reads matter while `cpu_rst_b`=0, but they are still served.
- Width rules:
  - index is 16 bits; comparison against N is 16-bit unsigned.
  - `load_count` saturates at 2^ADDR_W.

Test Plan:
- Reset release: rst high 3 cycles then low, `hatch_address`=5 -> `cpu_rst_b`=0 during rst and 1 one edge after. `hatch_instruction`=mem[5] one cycle after the address is applied (the store is not reset).
- Basic load: `ld_start`, then bytes 00 02 | 11 22 33 44 55 66 | AA BB CC DD EE FF with `ld_valid` held high.
  - `cpu_rst_b`=0 throughout the load.
  - After RELEASE, `cpu_rst_b`=1 and `load_count`=2.
  - Fetch 0 -> 48'h112233445566, fetch 1 -> 48'hAABBCCDDEEFF, each with 1-cycle latency.
- Stalled stream: same image with `ld_valid` toggling randomly and 10-cycle gaps -> identical contents, `load_err`=0.
- Edge counts:
  - N=0: `cpu_rst_b` goes low for exactly 3 cycles after `ld_start` (HDR_HI, HDR_LO, RELEASE), then high; `load_count`=0.
  - Out-of-range fetch: `hatch_address`=2^ADDR_W -> NOP_INSN.
- Overflow (ADDR_W=2): N=6 with 36 bytes -> `load_err`=1, `load_count`=4, all 36 bytes accepted, mem[0..3] hold the first four words, and the CPU is released.
- Reset mid-load: after header 00 03 and 8 data bytes, pulse rst -> state=RUN, `ld_ready`=0, mem[0] holds the new word, and `cpu_rst_b`=1 after rst. A following `ld_start` is honored.
